mem_stage: RTL

Memory-access stage of the 5-stage MIPS pipeline, downstream of the EX stage. It holds the EX/MEM pipeline register and runs a data-memory request/ready handshake with a bounded wait counter. It performs byte/halfword/word lane formatting and holds the MEM/WB pipeline register. It supplies the EX-stage bypass sources and the load-use indication, and stalls the whole upstream pipeline while a memory access is outstanding.

---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_align.sv | 45 ++++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM stage.
//   - data/address bus widths and register-address width
//   - MemSize encodings (byte/half/word)
//   - MEM-stage handshake FSM state encodings
//   - EX/MEM pipeline register layout
//   - misalignment helper used when MEM_ALIGN_CHECK_EN is defined
package mem_stage_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = XLEN / 8;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    MS_BYTE = 2'b00,
    MS_HALF = 2'b01,
    MS_WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   wdata;
    logic              rd;
    logic              wr;
    logic [1:0]        size;
    logic              sgn;
    logic              regwe;
    logic [REG_AW-1:0] regaddr;
  } exmem_t;

  // Half needs bit 0 clear, word needs bits 1:0 clear.
  function automatic logic misaligned(logic [1:0] size, logic [1:0] lo);
    return ((size == MS_HALF) && lo[0]) || ((size == MS_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational lane formatting for the data-memory port.
//   size_i    access size (MemSize encoding)
//   lane_i    byte lane = address bits 1:0 (little-endian)
//   signed_i  sign-extend loads
//   st_data_i raw store data       -> wdata_o  lane-replicated store data
//                                  -> byteen_o byte enables
//   rdata_i   raw memory read data -> ld_data_o extracted, extended load data
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]      size_i,
  input  logic [1:0]      lane_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [BE_W-1:0] byteen_o,
  output logic [XLEN-1:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata_i[8*lane_i +: 8];
    half_sel  = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wdata_o   = st_data_i;
    byteen_o  = 4'b1111;
    ld_data_o = rdata_i;
    case (size_i)
      MS_BYTE: begin
        wdata_o   = {4{st_data_i[7:0]}};
        byteen_o  = 4'b0001 << lane_i;
        ld_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      end
      MS_HALF: begin
        wdata_o   = {2{st_data_i[15:0]}};
        byteen_o  = 4'b0011 << lane_i;
        ld_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
//   EX_*       EX/MEM register inputs (loaded whenever Stall_Mem=0)
//   MEM_*      EX-stage bypass source and load-use indication
//   DMem_*     data-memory req/ready handshake and lane-formatted bus
//   Stall_Mem  freezes the upstream pipeline while an access waits
//   DMem_BusErr one-cycle pulse when an access is abandoned after WAIT_LIMIT
//   Mem_AlignErr misaligned access flag (only with MEM_ALIGN_CHECK_EN)
//   WB_*       MEM/WB register; WB_Data is the MEM_WB bypass source
// Optional feature macro: MEM_ALIGN_CHECK_EN. When undefined, misaligned
// addresses are silently aligned and Mem_AlignErr is tied 0.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_Valid,
  input  logic [XLEN-1:0]   EX_AluResult,
  input  logic [XLEN-1:0]   EX_DMem_WriteData,
  input  logic              EX_DMem_ReadEn,
  input  logic              EX_DMem_WriteEn,
  input  logic [1:0]        EX_MemSize,
  input  logic              EX_MemSigned,
  input  logic              EX_Reg_WriteEn,
  input  logic [REG_AW-1:0] EX_Reg_WriteAddr,
  output logic              MEM_Reg_WriteEn,
  output logic [REG_AW-1:0] MEM_Reg_WriteAddr,
  output logic              MEM_DMem_ReadEn,
  output logic [XLEN-1:0]   MEM_Forward_Data,
  output logic              DMem_Req,
  output logic              DMem_We,
  output logic [ADDR_W-1:0] DMem_Addr,
  output logic [BE_W-1:0]   DMem_ByteEn,
  output logic [XLEN-1:0]   DMem_WData,
  input  logic              DMem_Ready,
  input  logic [XLEN-1:0]   DMem_RData,
  output logic              Stall_Mem,
  output logic              DMem_BusErr,
  output logic              Mem_AlignErr,
  output logic              WB_Reg_WriteEn,
  output logic [REG_AW-1:0] WB_Reg_WriteAddr,
  output logic [XLEN-1:0]   WB_Data
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  exmem_t            ex_d, ex_q;
  mem_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mis, mem_op, req, done, abandon, stall;
  logic [ADDR_W-1:0] addr_eff;
  logic [XLEN-1:0]   fmt_wdata, fmt_ld;
  logic [BE_W-1:0]   fmt_be;

  // ---------------- EX/MEM register ----------------
  always_comb begin
    ex_d.valid   = EX_Valid;
    ex_d.alu     = EX_AluResult;
    ex_d.wdata   = EX_DMem_WriteData;
    ex_d.rd      = EX_Valid & EX_DMem_ReadEn;
    ex_d.wr      = EX_Valid & EX_DMem_WriteEn;
    ex_d.size    = EX_MemSize;
    ex_d.sgn     = EX_MemSigned;
    ex_d.regwe   = EX_Valid & EX_Reg_WriteEn;
    ex_d.regaddr = EX_Reg_WriteAddr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ex_q <= '0;
    else if (!stall) ex_q <= ex_d;
  end

  // ---------------- alignment ----------------
`ifdef MEM_ALIGN_CHECK_EN
  assign mis          = misaligned(ex_q.size, ex_q.alu[1:0]);
  assign addr_eff     = ex_q.alu;
  assign Mem_AlignErr = mem_op & mis;
`else
  assign mis          = 1'b0;
  assign Mem_AlignErr = 1'b0;
  always_comb begin
    addr_eff = ex_q.alu;
    if (ex_q.size == MS_HALF)      addr_eff[0]   = 1'b0;
    else if (ex_q.size != MS_BYTE) addr_eff[1:0] = 2'b00;
  end
`endif

  // ---------------- handshake ----------------
  // Req is purely combinational from the latched op, so it is raised in the
  // op's first MEM cycle and drops asynchronously when reset clears ex_q.
  assign mem_op  = ex_q.rd | ex_q.wr;
  assign req     = mem_op & ~mis;
  assign done    = req & DMem_Ready;
  // Ready in the limit cycle wins: abandon requires Ready low.
  assign abandon = req & ~DMem_Ready & (cnt_q == LIMIT);
  assign stall   = req & ~DMem_Ready & ~abandon;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts Ready-low cycles already spent on the current access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN:  if (stall) state_d = ST_WAIT;
      ST_WAIT: if (!stall) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    if (stall)          cnt_d = cnt_q + 8'd1;
    if (done | abandon) cnt_d = '0;
  end

  mem_align u_align (
    .size_i    (ex_q.size),
    .lane_i    (addr_eff[1:0]),
    .signed_i  (ex_q.sgn),
    .st_data_i (ex_q.wdata),
    .rdata_i   (DMem_RData),
    .wdata_o   (fmt_wdata),
    .byteen_o  (fmt_be),
    .ld_data_o (fmt_ld)
  );

  // ---------------- MEM/WB register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_Reg_WriteEn   <= 1'b0;
      WB_Reg_WriteAddr <= '0;
      WB_Data          <= '0;
    end else if (stall) begin
      WB_Reg_WriteEn   <= 1'b0;
    end else begin
      // misaligned and abandoned ops retire as bubbles
      WB_Reg_WriteEn   <= ex_q.regwe & ~mis & ~abandon;
      WB_Reg_WriteAddr <= ex_q.regaddr;
      WB_Data          <= ex_q.rd ? fmt_ld : ex_q.alu;
    end
  end

  // ---------------- outputs ----------------
  assign MEM_Reg_WriteEn   = ex_q.valid & ex_q.regwe;
  assign MEM_Reg_WriteAddr = ex_q.regaddr;
  assign MEM_DMem_ReadEn   = ex_q.rd;
  assign MEM_Forward_Data  = ex_q.alu;
  assign DMem_Req          = req;
  assign DMem_We           = req & ex_q.wr;
  assign DMem_Addr         = addr_eff;
  assign DMem_ByteEn       = req ? fmt_be : '0;
  assign DMem_WData        = (req & ex_q.wr) ? fmt_wdata : '0;
  assign Stall_Mem         = stall;
  assign DMem_BusErr       = abandon;

endmodule
